// File: rtl/main_sweep_controller.sv
// rtl/main_sweep_controller.sv - on-chip input sweep and response capture for the Main function block
//
// Purpose:
//   Steps dut_a through every code 0..2^WIDTH-1. Each code is held for
//   DWELL cycles, then dut_b is sampled. The run builds a truth table,
//   a ones count and a pass/fail comparison against exp_table.
//
// Parameters:
//   WIDTH  input width of the swept function (table size 2^WIDTH)
//   DWELL  cycles each code is held before sampling (1..15)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a sweep (honoured in IDLE only)
//   abort         abandon a running sweep
//   exp_table     expected response, bit i for A=i
//   dut_a         drives Main.A
//   dut_b         response from Main.B
//   busy          sweep in progress
//   done          one-cycle pulse at sweep completion
//   result_valid  results are complete and valid
//   table_out     captured response, bit i for A=i
//   ones_count    number of ones in table_out
//   fail          at least one bit mismatched exp_table
//   first_fail    lowest mismatching index (0 when fail=0)
module main_sweep_controller #(
  parameter int WIDTH = 5,
  parameter int DWELL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [(1<<WIDTH)-1:0]   exp_table,
  output logic [WIDTH-1:0]        dut_a,
  input  logic                    dut_b,
  output logic                    busy,
  output logic                    done,
  output logic                    result_valid,
  output logic [(1<<WIDTH)-1:0]   table_out,
  output logic [WIDTH:0]          ones_count,
  output logic                    fail,
  output logic [WIDTH-1:0]        first_fail
);

  localparam int TBL = 1 << WIDTH;
  localparam int CW  = WIDTH + 1;
  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(TBL - 1);
  localparam logic [3:0]       DWELL_L  = 4'(DWELL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_idx;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [TBL-1:0]   r_table;
  logic [WIDTH:0]   r_ones;
  logic             r_fail;
  logic [WIDTH-1:0] r_first;

  // Sample on the DWELL-th edge that dut_a has shown the current index.
  logic w_sample_edge;
  logic w_mismatch;
  logic w_last;

  assign w_sample_edge = (r_cnt == 4'd1);
  assign w_mismatch    = (dut_b != exp_table[r_idx]);
  assign w_last        = (r_idx == LAST_IDX);

  // r_idx is returned to 0 whenever the sweep ends, so it doubles as dut_a.
  assign dut_a        = r_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_valid;
  assign table_out    = r_table;
  assign ones_count   = r_ones;
  assign fail         = r_fail;
  assign first_fail   = r_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_table <= '0;
      r_ones  <= '0;
      r_fail  <= 1'b0;
      r_first <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_cnt   <= DWELL_L;
            r_table <= '0;
            r_ones  <= '0;
            r_fail  <= 1'b0;
            r_first <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            // Abort takes priority, even over the final sample.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
          end else if (w_sample_edge) begin
            r_table[r_idx] <= dut_b;
            r_ones         <= r_ones + CW'(dut_b);
            if (w_mismatch && !r_fail) begin
              r_fail  <= 1'b1;
              r_first <= r_idx;
            end
            // Final index detected explicitly rather than by wrap-around.
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
              r_idx   <= '0;
              r_cnt   <= '0;
            end else begin
              r_idx <= r_idx + WIDTH'(1);
              r_cnt <= DWELL_L;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_sweep_controller.sv
// tb/tb_main_sweep_controller.sv - directed self-checking bench for main_sweep_controller
module tb_main_sweep_controller;

  logic        clk;
  logic        rst_n;

  // Instance 0: defaults (WIDTH=5, DWELL=2)
  logic        start0, abort0;
  logic [31:0] exp0;
  logic [4:0]  a0;
  logic        b0;
  logic        busy0, done0, rv0, fail0;
  logic [31:0] tbl0;
  logic [5:0]  ones0;
  logic [4:0]  ff0;
  logic        tie_one;

  // Instance 1: DWELL=1
  logic        start1, abort1;
  logic [31:0] exp1;
  logic [4:0]  a1;
  logic        b1;
  logic        busy1, done1, rv1, fail1;
  logic [31:0] tbl1;
  logic [5:0]  ones1;
  logic [4:0]  ff1;

  int checks;
  int errors;

  // Stand-in for Main: 5-bit parity, or constant 1 when tie_one is set.
  assign b0 = tie_one ? 1'b1 : ^a0;
  assign b1 = ^a1;

  main_sweep_controller #(.WIDTH(5), .DWELL(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .exp_table(exp0), .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0),
    .result_valid(rv0), .table_out(tbl0), .ones_count(ones0),
    .fail(fail0), .first_fail(ff0)
  );

  main_sweep_controller #(.WIDTH(5), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .exp_table(exp1), .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1),
    .result_valid(rv1), .table_out(tbl1), .ones_count(ones1),
    .fail(fail1), .first_fail(ff1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on instance 0 and run until done; returns the cycle
  // (counted from the start edge) in which done is seen and busy cycles.
  task automatic sweep0(output int cyc, output int busy_cyc);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    busy_cyc = 0;
    while (!done0 && cyc < 300) begin
      busy_cyc += int'(busy0);
      tick();
      cyc++;
    end
  endtask

  int cyc, bcyc, guard;
  logic saw_done;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; exp0 = 32'h9669_6996; tie_one = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; exp1 = 32'h9669_6996;
    #12;
    check("reset_busy", 64'(busy0), 64'd0);
    check("reset_dut_a", 64'(a0), 64'd0);
    check("reset_valid", 64'(rv0), 64'd0);
    check("reset_table", 64'(tbl0), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1. Parity sweep with matching expectation
    sweep0(cyc, bcyc);
    check("par_done_cycle", 64'(cyc), 64'd65);
    check("par_busy_cycles", 64'(bcyc), 64'd64);
    check("par_valid", 64'(rv0), 64'd1);
    check("par_busy_in_done", 64'(busy0), 64'd0);
    check("par_table", 64'(tbl0), 64'h9669_6996);
    check("par_ones", 64'(ones0), 64'd16);
    check("par_fail", 64'(fail0), 64'd0);
    check("par_first_fail", 64'(ff0), 64'd0);
    tick();
    check("par_done_one_cycle", 64'(done0), 64'd0);
    check("par_valid_held", 64'(rv0), 64'd1);
    tick();

    // 2. Tied-1 response, one expected zero at index 5
    tie_one = 1'b1;
    exp0 = 32'hFFFF_FFDF;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t1_valid_drop", 64'(rv0), 64'd0);
    check("t1_busy_start", 64'(busy0), 64'd1);
    check("t1_dut_a_start", 64'(a0), 64'd0);
    cyc = 1;
    while (!done0 && cyc < 300) begin tick(); cyc++; end
    check("t1_done_cycle", 64'(cyc), 64'd65);
    check("t1_ones", 64'(ones0), 64'd32);
    check("t1_table", 64'(tbl0), 64'hFFFF_FFFF);
    check("t1_fail", 64'(fail0), 64'd1);
    check("t1_first_fail", 64'(ff0), 64'd5);
    tick();
    tick();

    // 3. Parity response against all-zero expectation
    tie_one = 1'b0;
    exp0 = 32'h0;
    sweep0(cyc, bcyc);
    check("z_done_cycle", 64'(cyc), 64'd65);
    check("z_fail", 64'(fail0), 64'd1);
    check("z_first_fail", 64'(ff0), 64'd1);
    check("z_ones", 64'(ones0), 64'd16);
    tick();
    tick();

    // 4. Abort while dut_a = 10
    exp0 = 32'h9669_6996;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    guard = 0;
    while (a0 != 5'd10 && guard < 100) begin tick(); guard++; end
    check("ab_reached_10", 64'(a0), 64'd10);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("ab_busy", 64'(busy0), 64'd0);
    check("ab_dut_a", 64'(a0), 64'd0);
    check("ab_valid", 64'(rv0), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done0) saw_done = 1'b1;
      tick();
    end
    check("ab_no_done", 64'(saw_done), 64'd0);
    check("ab_valid_later", 64'(rv0), 64'd0);
    sweep0(cyc, bcyc);
    check("ab_resweep_cycle", 64'(cyc), 64'd65);
    check("ab_resweep_table", 64'(tbl0), 64'h9669_6996);
    check("ab_resweep_ones", 64'(ones0), 64'd16);
    check("ab_resweep_fail", 64'(fail0), 64'd0);
    tick();
    tick();

    // 5. Asynchronous reset while dut_a = 20
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    guard = 0;
    while (a0 != 5'd20 && guard < 100) begin tick(); guard++; end
    check("rst_reached_20", 64'(a0), 64'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_dut_a", 64'(a0), 64'd0);
    check("rst_table", 64'(tbl0), 64'd0);
    check("rst_ones", 64'(ones0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_rel_busy", 64'(busy0), 64'd0);
    check("rst_rel_valid", 64'(rv0), 64'd0);

    // 6. DWELL=1: per-cycle stepping, ignored starts, back-to-back restart
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    check("d1_dut_a_c1", 64'(a1), 64'd0);
    tick(); cyc++;
    check("d1_dut_a_c2", 64'(a1), 64'd1);
    tick(); cyc++;
    check("d1_dut_a_c3", 64'(a1), 64'd2);
    while (!done1 && cyc < 300) begin
      start1 = (cyc >= 5 && cyc <= 10) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start1 = 1'b0;
    check("d1_done_cycle", 64'(cyc), 64'd33);
    check("d1_table", 64'(tbl1), 64'h9669_6996);
    check("d1_fail", 64'(fail1), 64'd0);
    tick();
    check("d1_idle_valid", 64'(rv1), 64'd1);
    check("d1_idle_busy", 64'(busy1), 64'd0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("d1_restart_valid", 64'(rv1), 64'd0);
    check("d1_restart_busy", 64'(busy1), 64'd1);
    cyc = 1;
    while (!done1 && cyc < 300) begin tick(); cyc++; end
    check("d1_restart_cycle", 64'(cyc), 64'd33);
    check("d1_restart_ones", 64'(ones1), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_sweep_controller.md
# main_sweep_controller

Sequencer that drives the 5-bit combinational `Main` function block through all input codes in hardware and captures its 1-bit response. It replaces the hand-written stimulus sweep with an on-chip run. Each run produces a 2^WIDTH-bit truth table, a ones count and a pass/fail comparison against an expected table. It sits between `Main` (which it drives and samples) and the board-level control/status logic (start/abort in, results out).

## Interface
Parameters:
- `WIDTH`, 5, input width of the swept function; table size is 2^WIDTH.
- `DWELL`, 2, cycles each input code is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; sampled in IDLE only.
- `abort`  in  1  synchronous abort of a running sweep.
- `exp_table`  in  2^WIDTH  expected response, bit i = expected B for A=i; held stable while busy.
- `dut_a`  out  WIDTH  drives `Main.A`.
- `dut_b`  in  1  from `Main.B`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at sweep completion.
- `result_valid`  out  1  results below are complete and valid.
- `table_out`  out  2^WIDTH  captured response, bit i = B sampled for A=i.
- `ones_count`  out  WIDTH+1  number of 1s in `table_out` (0..2^WIDTH, no wrap).
- `fail`  out  1  at least one bit mismatched `exp_table`.
- `first_fail`  out  WIDTH  lowest mismatching index; 0 when `fail`=0.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE:
  - `dut_a`=0 and `busy`=0.
  - `start`=1 at an edge: idx←0, dwell counter←DWELL, clear `table_out`, `ones_count`, `fail` and `first_fail`, drop `result_valid`, go to SETTLE.
- SETTLE:
  - `dut_a`=idx and `busy`=1; the counter decrements each edge.
  - At the edge where counter=1 (the DWELL-th edge with `dut_a`=idx), sample:
    - `table_out[idx]`←`dut_b`.
    - `ones_count`+=`dut_b`.
    - If `dut_b`≠`exp_table[idx]` and `fail`=0: `fail`←1, `first_fail`←idx. Later mismatches do not overwrite `first_fail`.
  - On the same edge, if idx=2^WIDTH−1, go to DONE. Otherwise idx←idx+1 and counter←DWELL.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle; `result_valid`←1.
  - Next state is IDLE. `start` is ignored in DONE.
- `abort`=1 in SETTLE: go to IDLE on that edge. No `done` pulse; `result_valid` stays 0; partial table contents are undefined to consumers.
  - `abort` wins over a simultaneous final sample.
  - `abort` in IDLE or DONE has no effect.
- `start` while busy is ignored; there is no queued request.
- Results hold in IDLE until the next accepted `start`, abort or reset.
- idx is WIDTH bits; the final index is detected explicitly, with no reliance on wrap-around.

## Timing
- All outputs reset to 0 asynchronously on `rst_n`=0: state IDLE, `dut_a`=0, all flags/counts/table cleared.
- Reset mid-sweep abandons the run immediately; the block comes up in IDLE on release.
- `start` is accepted at edge E0. `busy`=1 and `dut_a`=0 from the cycle after E0.
- Sample edges fall at E0+k·DWELL for k=1..2^WIDTH.
- `done` is high in the cycle after edge E0+2^WIDTH·DWELL. With defaults that is edge 64, so `done` is visible in cycle 65.
- `dut_a` changes only on a sample edge, giving `Main` a full DWELL cycles to settle.
- `result_valid` rises together with `done` and falls in the cycle after the next accepted `start` or abort.
- `start` may be re-asserted in the IDLE cycle immediately following DONE.

## Test plan
- Defaults, `dut_b` = 5-bit XOR parity of `dut_a`, `exp_table`=0x96696996, pulse `start`:
  - `done` one cycle, 65 cycles after the start edge; `busy` high 64 cycles.
  - `table_out`=0x96696996, `ones_count`=16, `fail`=0, `first_fail`=0.
- `dut_b` tied 1, `exp_table`=0xFFFFFFDF → `ones_count`=32 (6-bit, no wrap), `fail`=1, `first_fail`=5.
- `exp_table`=0, parity DUT → `fail`=1 and `first_fail`=1; later mismatches at 2, 4, 7 … leave `first_fail` unchanged.
- `abort` while `dut_a`=10:
  - Next cycle `busy`=0 and `dut_a`=0.
  - No `done` pulse; `result_valid`=0.
  - Then `start` gives a clean full sweep with correct results.
- `rst_n` low while `dut_a`=20 → all outputs 0 immediately, without waiting for a clock; on release, IDLE with `result_valid`=0.
- DWELL=1: `dut_a` steps every cycle and `done` arrives 33 cycles after the start edge. `start` pulses during the sweep are ignored. `start` in the IDLE cycle right after `done` begins a new sweep, and `result_valid` drops the following cycle.
